// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Round-robin arbiter sharing one bank port of the two-bank SDRAM
//            controller among NREQ byte-wide requesters. One access is issued
//            per controller slot (sync strobe, every 8 clocks). Read data is
//            returned on the slot after the read was accepted and is steered
//            back to the requester that issued it.
//
// Parameters:
//   NREQ       - number of requesters (2..8)
//   ADDR_DEPTH - byte address width (controller per-bank address width)
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   sync              - controller slot strobe (command sampled this cycle)
//   rdy               - controller ready; nothing is issued while low
//   req[NREQ]         - per-requester request, held until ack
//   we[NREQ]          - per-requester write (1) / read (0)
//   addr[NREQ*AD]     - packed addresses, requester i at [i*AD +: AD]
//   wdata[NREQ*8]     - packed write bytes, requester i at [i*8 +: 8]
//   ack[NREQ]         - one-hot pulse on the accepting sync cycle
//   rvalid[NREQ]      - one-hot pulse while rdata holds that requester's byte
//   rdata[8]          - shared read byte, held until the next read return
//   port_addr/rd/wr/wdata - command to the controller bank
//   port_rdata[8]     - read data from the controller bank
//
// Configuration macro:
//   SDRAM_ARB_PRIO0_EN - when defined, requester 0 has fixed top priority and
//                        its grants leave the round-robin pointer untouched.
//
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_DEPTH = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sync,
    input  logic                       rdy,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            we,
    input  logic [NREQ*ADDR_DEPTH-1:0] addr,
    input  logic [NREQ*8-1:0]          wdata,
    output logic [NREQ-1:0]            ack,
    output logic [NREQ-1:0]            rvalid,
    output logic [7:0]                 rdata,
    output logic [ADDR_DEPTH-1:0]      port_addr,
    output logic                       port_rd,
    output logic                       port_wr,
    output logic [7:0]                 port_wdata,
    input  logic [7:0]                 port_rdata
);

    localparam int                 c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(NREQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] rr_ptr_q,  rr_ptr_d;
    logic               rd_pend_q, rd_pend_d;
    logic [c_ptr_w-1:0] rd_id_q,   rd_id_d;
    logic [NREQ-1:0]    rv_q,      rv_d;
    logic [7:0]         rdata_q,   rdata_d;

    // ------------------------------------------------------------------
    // Combinational selection
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] w_rr_sel;
    logic               w_found;
    logic [c_ptr_w-1:0] w_sel;
    logic [NREQ-1:0]    w_sel_oh;
    logic               w_sel_we;
    logic               w_gnt_v;
    logic               w_grant;

    // (base + off) mod NREQ, valid for base < NREQ and off < NREQ
    function automatic logic [c_ptr_w-1:0] f_wrap(input logic [c_ptr_w-1:0] base,
                                                  input int                 off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return c_ptr_w'(s);
    endfunction

    // First requester at or above rr_ptr, wrapping around
    always_comb begin
        w_rr_sel = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[f_wrap(rr_ptr_q, k)]) begin
                w_found  = 1'b1;
                w_rr_sel = f_wrap(rr_ptr_q, k);
            end
        end
    end

`ifdef SDRAM_ARB_PRIO0_EN
    // Requester 0 overrides the rotation; when it is idle the scan above
    // naturally rotates among requesters 1..NREQ-1.
    assign w_sel = req[0] ? '0 : w_rr_sel;
`else
    assign w_sel = w_rr_sel;
`endif

    assign w_gnt_v = |req;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel_oh
        assign w_sel_oh[gi] = (w_sel == c_ptr_w'(gi));
    end

    // Payload mux for the selected requester
    always_comb begin
        port_addr  = addr[ADDR_DEPTH-1:0];
        port_wdata = wdata[7:0];
        w_sel_we   = we[0];
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_oh[i]) begin
                port_addr  = addr[i*ADDR_DEPTH +: ADDR_DEPTH];
                port_wdata = wdata[i*8 +: 8];
                w_sel_we   = we[i];
            end
        end
    end

    // Strobes are masked during reset so the controller never sees a
    // command while the arbiter state is being cleared.
    assign w_grant = sync & rdy & w_gnt_v & ~rst;
    assign port_wr = ~rst & w_gnt_v & rdy &  w_sel_we;
    assign port_rd = ~rst & w_gnt_v & rdy & ~w_sel_we;
    assign ack     = w_grant ? w_sel_oh : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rd_pend_d = rd_pend_q;
        rd_id_d   = rd_id_q;
        rv_d      = '0;
        rdata_d   = rdata_q;

        // Return the byte of the read accepted one slot earlier
        if (sync && rd_pend_q) begin
            rdata_d   = port_rdata;
            rd_pend_d = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                rv_d[i] = (rd_id_q == c_ptr_w'(i));
            end
        end

        // A read granted on the return slot re-arms the pending flag
        if (w_grant) begin
`ifdef SDRAM_ARB_PRIO0_EN
            if (w_sel != '0) begin
                rr_ptr_d = (w_sel == c_last) ? '0 : w_sel + 1'b1;
            end
`else
            rr_ptr_d = (w_sel == c_last) ? '0 : w_sel + 1'b1;
`endif
            if (!w_sel_we) begin
                rd_pend_d = 1'b1;
                rd_id_d   = w_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
            rv_q      <= '0;
            rdata_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
            rv_q      <= rv_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rvalid = rv_q;
    assign rdata  = rdata_q;

endmodule
`default_nettype wire
